// File: rtl/stage_mem_lsu.sv
// MEM-stage load/store unit: one req/ack data-bus access per request, byte-lane steering and load extension.
// Optional `MISALIGN_TRAP_EN` rejects misaligned halfword/word accesses before they reach the bus.
module stage_mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       aluout,
  input  logic [31:0]       reg_data2,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              is_load_q, is_load_d;

  logic              ld_ok_s;
  logic              st_ok_s;
  logic              misalign_s;
  logic              timeout_s;

  // Pick the addressed byte/halfword out of the read word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rd;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Request legality and alignment decode on the live EX inputs.
  always_comb begin
    ld_ok_s = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    st_ok_s = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
`ifdef MISALIGN_TRAP_EN
    misalign_s = ((funct3[1:0] == 2'b01) && aluout[0]) ||
                 ((funct3[1:0] == 2'b10) && (aluout[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    timeout_s = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
  end

  // Next-state and next-output logic; every output is loaded into a register.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    load_data_d  = load_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    timer_d      = timer_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    is_load_d    = is_load_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d    = funct3;
          lane_d      = aluout[1:0];
          is_load_d   = memread;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (memread == memwrite) begin
            // Neither flag is a pass-through; both set is an illegal request.
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            err_d        = memread;
            load_data_d  = 32'h0000_0000;
          end else if ((memread && !ld_ok_s) || (memwrite && !st_ok_s) || misalign_s) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            load_data_d  = 32'h0000_0000;
          end else begin
            state_d    = S_BUS;
            mem_req_d  = 1'b1;
            mem_we_d   = memwrite;
            mem_addr_d = {aluout[ADDR_W-1:2], 2'b00};
            timer_d    = '0;
            if (memwrite) begin
              case (funct3[1:0])
                2'b00: begin
                  mem_wstrb_d = 4'b0001 << aluout[1:0];
                  mem_wdata_d = {4{reg_data2[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_d = aluout[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_d = {2{reg_data2[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'b1111;
                  mem_wdata_d = reg_data2;
                end
              endcase
            end else begin
              mem_wstrb_d = 4'b0000;
              mem_wdata_d = 32'h0000_0000;
            end
          end
        end else begin
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          state_d      = S_DONE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          load_data_d  = is_load_q ? load_extend(funct3_q, lane_q, mem_rdata) : 32'h0000_0000;
        end else if (timeout_s) begin
          state_d      = S_DONE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          load_data_d  = 32'h0000_0000;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding access without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      load_data_q  <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0000_0000;
      mem_wstrb_q  <= 4'b0000;
      timer_q      <= '0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      load_data_q  <= load_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      timer_q      <= timer_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      is_load_q    <= is_load_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign err        = err_q;
  assign load_data  = load_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule
